// File: rtl/bpu_ras_ckpt.sv
// Return address stack for the branch prediction unit with checkpoint/restore.
// A circular stack of DEPTH entries (valid bit + return address). Calls push,
// returns pop, and the verify stage can roll the stack back to a checkpoint.
// Optional feature macro: RAS_REPEAT_COUNTER_EN (per-entry 4-bit repeat counter).
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   push_valid, push_addr         predicted call and its return address
//   pop_valid                     predicted return
//   restore_valid, restore_ptr,
//   restore_count, restore_top    mispredict recovery: reload checkpoint
//   top_valid, top_addr           predicted return target
//   ckpt_ptr, ckpt_count, ckpt_top  current state, carried down the pipe
//   full, empty                   occupancy flags
//   pop_underflow                 one-cycle pulse after a pop while empty
//   ckpt_rc, restore_rc           repeat counter checkpoint (feature only)
module bpu_ras_ckpt #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              pop_valid,
  input  logic              restore_valid,
  input  logic [PTR_W-1:0]  restore_ptr,
  input  logic [CNT_W-1:0]  restore_count,
  input  logic [ADDR_W-1:0] restore_top,
`ifdef RAS_REPEAT_COUNTER_EN
  input  logic [3:0]        restore_rc,
  output logic [3:0]        ckpt_rc,
`endif
  output logic              top_valid,
  output logic [ADDR_W-1:0] top_addr,
  output logic [PTR_W-1:0]  ckpt_ptr,
  output logic [CNT_W-1:0]  ckpt_count,
  output logic [ADDR_W-1:0] ckpt_top,
  output logic              full,
  output logic              empty,
  output logic              pop_underflow
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0]  sp_q, sp_d, sp_inc, sp_dec;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              uf_q, uf_d;
  logic [DEPTH-1:0]  vld_q;
  logic [ADDR_W-1:0] data_q [DEPTH];

  logic              wr_en, clr_en;
  logic [PTR_W-1:0]  wr_idx;
  logic [ADDR_W-1:0] wr_data;
  logic              top_vld;
  logic              rpt_push, rpt_pop;

  assign sp_inc  = sp_q + PTR_W'(1);
  assign sp_dec  = sp_q - PTR_W'(1);
  assign top_vld = (cnt_q != '0) && vld_q[sp_q];

`ifdef RAS_REPEAT_COUNTER_EN
  logic [3:0] rc_q [DEPTH];

  // Repeated call to the same target only bumps the top counter
  assign rpt_push = top_vld && (push_addr == data_q[sp_q]) && (rc_q[sp_q] != 4'd15);
  assign rpt_pop  = (cnt_q != '0) && (rc_q[sp_q] != 4'd0);
  assign ckpt_rc  = rc_q[sp_q];

  // Repeat counter storage follows the same priority as the main stack
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) rc_q[i] <= 4'd0;
    end else if (restore_valid) begin
      rc_q[restore_ptr] <= restore_rc;
    end else if (push_valid && pop_valid) begin
      rc_q[sp_q] <= 4'd0;
    end else if (push_valid) begin
      if (rpt_push) rc_q[sp_q] <= rc_q[sp_q] + 4'd1;
      else          rc_q[sp_inc] <= 4'd0;
    end else if (pop_valid && rpt_pop) begin
      rc_q[sp_q] <= rc_q[sp_q] - 4'd1;
    end
  end
`else
  assign rpt_push = 1'b0;
  assign rpt_pop  = 1'b0;
`endif

  // Next-state: restore beats push/pop; push+pop replaces the top in place
  always_comb begin
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    uf_d    = 1'b0;
    wr_en   = 1'b0;
    clr_en  = 1'b0;
    wr_idx  = sp_q;
    wr_data = push_addr;
    if (restore_valid) begin
      sp_d    = restore_ptr;
      cnt_d   = restore_count;
      wr_en   = (restore_count != '0);
      wr_idx  = restore_ptr;
      wr_data = restore_top;
    end else if (push_valid && pop_valid) begin
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (push_valid) begin
      if (!rpt_push) begin
        sp_d   = sp_inc;
        wr_en  = 1'b1;
        wr_idx = sp_inc;
        // Full push overwrites the oldest entry; occupancy saturates
        if (cnt_q != FULL_CNT) cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (pop_valid) begin
      if (cnt_q == '0) begin
        uf_d = 1'b1;
      end else if (!rpt_pop) begin
        clr_en = 1'b1;
        sp_d   = sp_dec;
        cnt_d  = cnt_q - CNT_W'(1);
      end
    end
  end

  // Pointer, occupancy, valid bits and underflow flag
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q  <= '0;
      cnt_q <= '0;
      uf_q  <= 1'b0;
      vld_q <= '0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      uf_q  <= uf_d;
      if (wr_en)       vld_q[wr_idx] <= 1'b1;
      else if (clr_en) vld_q[sp_q]   <= 1'b0;
    end
  end

  // Address storage needs no reset: it is only observed through a valid bit
  always_ff @(posedge clk) begin
    if (!reset && wr_en) data_q[wr_idx] <= wr_data;
  end

  assign top_valid     = top_vld;
  assign top_addr      = top_vld ? data_q[sp_q] : '0;
  assign ckpt_ptr      = sp_q;
  assign ckpt_count    = cnt_q;
  assign ckpt_top      = top_addr;
  assign full          = (cnt_q == FULL_CNT);
  assign empty         = (cnt_q == '0);
  assign pop_underflow = uf_q;

endmodule
